// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
// ---------------
// Sequencing controller for the C = A * B MAC datapath. A job of M x K times
// K x N is walked in (i, j, k) order with k innermost. Every index produces
// one operand-fetch beat carrying the A and B element addresses and the
// accumulate first/last flags. MAC_LAT cycles after each element's final beat
// is accepted, one C write address is emitted.
//
// Optional feature: define MATMUL_SEQ_PERF_EN to build the busy-cycle and
// stall-cycle performance counters. Without it both perf ports are tied to 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          job request (sampled in IDLE), synchronous cancel
//   cfg_m, cfg_n, cfg_k   job dimensions, latched when a job starts
//   busy, done, err       status; done/err are one-cycle pulses
//   rd_valid, rd_ready    operand beat handshake
//   rd_addr_a, rd_addr_b  A and B element addresses of the current beat
//   mac_first, mac_last   k == 0 / k == K-1 for the current beat
//   wr_valid, wr_addr     C result write (no backpressure)
//   perf_cycles/stalls    performance counters (optional feature)
//
// Handshake: a beat transfers on any rising edge where rd_valid && rd_ready.
// Once rd_valid is raised it stays high, and rd_addr_a, rd_addr_b, mac_first
// and mac_last stay stable, until the beat transfers (abort excepted).
// rd_valid never depends combinationally on rd_ready.

module matmul_seq_ctrl #(
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [DIM_W-1:0]  cfg_k,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mac_first,
  output logic              mac_last,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;

  // Latched job dimensions
  logic [DIM_W-1:0]   m_r, n_r, k_r;

  // Index counters
  logic [DIM_W-1:0]   i_idx, j_idx, k_idx;

  // Incremental address bases: row_a = i*K, kn = k*N, row_c = i*N
  logic [ADDR_W-1:0]  row_a, kn, row_c;

  logic               rd_valid_r;
  logic               done_r;
  logic               err_r;

  // Write pipeline; stage MAC_LAT-1 is the output stage
  logic               pipe_v [MAC_LAT];
  logic [ADDR_W-1:0]  pipe_a [MAC_LAT];

  logic               accept;
  logic               k_last, j_last, i_last;
  logic               early_v;

  assign accept = rd_valid_r && rd_ready;

  // Terminal compares against cfg-1 so that 2^DIM_W-1 is a usable dimension.
  assign k_last = (k_idx == k_r - DIM_W'(1));
  assign j_last = (j_idx == n_r - DIM_W'(1));
  assign i_last = (i_idx == m_r - DIM_W'(1));

  assign busy      = (state != S_IDLE);
  assign done      = done_r;
  assign err       = err_r;
  assign rd_valid  = rd_valid_r;
  assign rd_addr_a = row_a + ADDR_W'(k_idx);
  assign rd_addr_b = kn + ADDR_W'(j_idx);
  // Flags are gated so they read 0 whenever no beat is offered.
  assign mac_first = rd_valid_r && (k_idx == '0);
  assign mac_last  = rd_valid_r && k_last;
  assign wr_valid  = pipe_v[MAC_LAT-1];
  assign wr_addr   = pipe_a[MAC_LAT-1];

  // Any write still in flight ahead of the output stage.
  always_comb begin
    early_v = 1'b0;
    for (int s = 0; s < int'(MAC_LAT) - 1; s++) begin
      early_v = early_v | pipe_v[s];
    end
  end

  // Control FSM and index/address walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      m_r        <= '0;
      n_r        <= '0;
      k_r        <= '0;
      i_idx      <= '0;
      j_idx      <= '0;
      k_idx      <= '0;
      row_a      <= '0;
      kn         <= '0;
      row_c      <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        rd_valid_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              m_r   <= cfg_m;
              n_r   <= cfg_n;
              k_r   <= cfg_k;
              i_idx <= '0;
              j_idx <= '0;
              k_idx <= '0;
              row_a <= '0;
              kn    <= '0;
              row_c <= '0;
              if (cfg_m == '0 || cfg_n == '0 || cfg_k == '0) begin
                state  <= S_DONE;
                done_r <= 1'b1;
                err_r  <= 1'b1;
              end else begin
                state      <= S_RUN;
                rd_valid_r <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (accept) begin
              if (!k_last) begin
                k_idx <= k_idx + DIM_W'(1);
                kn    <= kn + ADDR_W'(n_r);
              end else begin
                k_idx <= '0;
                kn    <= '0;
                if (!j_last) begin
                  j_idx <= j_idx + DIM_W'(1);
                end else begin
                  j_idx <= '0;
                  if (i_last) begin
                    state      <= S_DRAIN;
                    rd_valid_r <= 1'b0;
                  end else begin
                    i_idx <= i_idx + DIM_W'(1);
                    row_a <= row_a + ADDR_W'(k_r);
                    row_c <= row_c + ADDR_W'(n_r);
                  end
                end
              end
            end
          end
          S_DRAIN: begin
            // The final write is the one at the output stage with nothing
            // queued behind it.
            if (pipe_v[MAC_LAT-1] && !early_v) begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Write pipeline: shifts every cycle regardless of rd_ready. The C address
  // is captured from row_c + j at the accept edge of the element's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(MAC_LAT); s++) begin
        pipe_v[s] <= 1'b0;
        pipe_a[s] <= '0;
      end
    end else begin
      pipe_v[0] <= accept && k_last && !abort;
      pipe_a[0] <= row_c + ADDR_W'(j_idx);
      for (int s = 1; s < int'(MAC_LAT); s++) begin
        pipe_v[s] <= pipe_v[s-1] && !abort;
        pipe_a[s] <= pipe_a[s-1];
      end
    end
  end

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_cycles_r;
  logic [31:0] perf_stalls_r;

  // Cleared when a job actually starts; otherwise they keep counting while
  // busy and hold once the job has finished. Both saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_r <= '0;
      perf_stalls_r <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      perf_cycles_r <= '0;
      perf_stalls_r <= '0;
    end else begin
      if (state != S_IDLE && perf_cycles_r != '1) begin
        perf_cycles_r <= perf_cycles_r + 32'd1;
      end
      if (rd_valid_r && !rd_ready && perf_stalls_r != '1) begin
        perf_stalls_r <= perf_stalls_r + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_r;
  assign perf_stalls = perf_stalls_r;
`else
  assign perf_cycles = 32'd0;
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Testbench for matmul_seq_ctrl: directed jobs with hand-computed address
// sequences, write timings and completion times, plus abort/reset cases.

module tb_matmul_seq_ctrl;

  localparam int DIM_W   = 8;
  localparam int ADDR_W  = 16;
  localparam int MAC_LAT = 3;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [DIM_W-1:0]  cfg_m, cfg_n, cfg_k;
  logic              busy, done, err;
  logic              rd_valid, rd_ready;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic              mac_first, mac_last;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       perf_cycles, perf_stalls;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_seq_ctrl #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_m      (cfg_m),
    .cfg_n      (cfg_n),
    .cfg_k      (cfg_k),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] a_log[$], b_log[$], f_log[$], l_log[$];
  logic [31:0] wa_log[$], wt_log[$], dt_log[$], de_log[$];
  int          rv_cnt = 0;
  int          t0 = 0;
  logic        stab_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_beat = '0;
  logic [34:0] cur_beat;
  logic        seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_list(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
    end
  endtask

  // Negedge monitor: records every accepted beat, write and done pulse with
  // its time relative to the start cycle.
  always @(negedge clk) begin
    cur_beat = {rd_valid, rd_addr_a, rd_addr_b, mac_first, mac_last};
    if (rd_valid) rv_cnt++;
    if (rd_valid && rd_ready) begin
      a_log.push_back(32'(rd_addr_a));
      b_log.push_back(32'(rd_addr_b));
      f_log.push_back(32'(mac_first));
      l_log.push_back(32'(mac_last));
    end
    if (wr_valid) begin
      wa_log.push_back(32'(wr_addr));
      wt_log.push_back(32'(cyc - t0));
    end
    if (done) begin
      dt_log.push_back(32'(cyc - t0));
      de_log.push_back(32'(err));
    end
    if (stab_en && prev_stall) check("stall_hold", 64'(cur_beat), 64'(prev_beat));
    prev_stall = rd_valid && !rd_ready;
    prev_beat  = cur_beat;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    a_log.delete(); b_log.delete(); f_log.delete(); l_log.delete();
    wa_log.delete(); wt_log.delete(); dt_log.delete(); de_log.delete();
    rv_cnt = 0;
  endtask

  // Called just after a rising edge; that cycle becomes T.
  task automatic start_job(input int m, input int n, input int k);
    cfg_m = DIM_W'(m);
    cfg_n = DIM_W'(n);
    cfg_k = DIM_W'(k);
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  // Stall mode drops rd_ready on odd cycles after T (first RUN cycle stalls).
  task automatic wait_done(input bit stall, input int budget, output logic got_done);
    got_done = 1'b0;
    for (int n = 0; n < budget && !got_done; n++) begin
      rd_ready = stall ? ((cyc - t0) % 2 == 0) : 1'b1;
      @(negedge clk);
      if (done) got_done = 1'b1;
      tick();
    end
    rd_ready = 1'b1;
  endtask

  task automatic check_quiet(input string p);
    check({p, "_busy"},   64'(busy),        64'd0);
    check({p, "_done"},   64'(done),        64'd0);
    check({p, "_err"},    64'(err),         64'd0);
    check({p, "_rdv"},    64'(rd_valid),    64'd0);
    check({p, "_addr_a"}, 64'(rd_addr_a),   64'd0);
    check({p, "_addr_b"}, 64'(rd_addr_b),   64'd0);
    check({p, "_first"},  64'(mac_first),   64'd0);
    check({p, "_last"},   64'(mac_last),    64'd0);
    check({p, "_wrv"},    64'(wr_valid),    64'd0);
    check({p, "_wra"},    64'(wr_addr),     64'd0);
    check({p, "_pcyc"},   64'(perf_cycles), 64'd0);
    check({p, "_pstl"},   64'(perf_stalls), 64'd0);
  endtask

  task automatic check_2x2x2_beats(input string p);
    exp_q = '{0, 1, 0, 1, 2, 3, 2, 3};
    check_list({p, "_a"}, a_log, exp_q);
    exp_q = '{0, 2, 1, 3, 0, 2, 1, 3};
    check_list({p, "_b"}, b_log, exp_q);
    exp_q = '{1, 0, 1, 0, 1, 0, 1, 0};
    check_list({p, "_first"}, f_log, exp_q);
    exp_q = '{0, 1, 0, 1, 0, 1, 0, 1};
    check_list({p, "_last"}, l_log, exp_q);
    exp_q = '{0, 1, 2, 3};
    check_list({p, "_wra"}, wa_log, exp_q);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    cfg_m    = '0;
    cfg_n    = '0;
    cfg_k    = '0;
    rd_ready = 1'b1;

    #12;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // 2x2x2, rd_ready high
    clear_logs();
    start_job(2, 2, 2);
    wait_done(1'b0, 40, seen);
    check("t1_done_seen", 64'(seen), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);
    check_2x2x2_beats("t1");
    exp_q = '{5, 7, 9, 11};
    check_list("t1_wrt", wt_log, exp_q);
    exp_q = '{12};
    check_list("t1_done_t", dt_log, exp_q);
    exp_q = '{0};
    check_list("t1_err", de_log, exp_q);
`ifdef MATMUL_SEQ_PERF_EN
    check("t1_pcyc", 64'(perf_cycles), 64'd12);
    check("t1_pstl", 64'(perf_stalls), 64'd0);
`else
    check("t1_pcyc", 64'(perf_cycles), 64'd0);
    check("t1_pstl", 64'(perf_stalls), 64'd0);
`endif
    tick();

    // 2x2x2 with rd_ready low every other cycle
    clear_logs();
    start_job(2, 2, 2);
    stab_en = 1'b1;
    wait_done(1'b1, 60, seen);
    stab_en = 1'b0;
    check("t2_done_seen", 64'(seen), 64'd1);
    check_2x2x2_beats("t2");
    exp_q = '{7, 11, 15, 19};
    check_list("t2_wrt", wt_log, exp_q);
    exp_q = '{20};
    check_list("t2_done_t", dt_log, exp_q);
`ifdef MATMUL_SEQ_PERF_EN
    check("t2_pcyc", 64'(perf_cycles), 64'd20);
    check("t2_pstl", 64'(perf_stalls), 64'd8);
`else
    check("t2_pcyc", 64'(perf_cycles), 64'd0);
    check("t2_pstl", 64'(perf_stalls), 64'd0);
`endif
    tick();

    // cfg_k = 0: error completion, no beats
    clear_logs();
    start_job(2, 2, 0);
    wait_done(1'b0, 20, seen);
    tick(); tick();
    check("t3_done_seen", 64'(seen), 64'd1);
    exp_q = '{1};
    check_list("t3_done_t", dt_log, exp_q);
    exp_q = '{1};
    check_list("t3_err", de_log, exp_q);
    check("t3_rdv_cycles", 64'(rv_cnt), 64'd0);
    check("t3_wr_count", 64'(wa_log.size()), 64'd0);

    // 1x1x1
    clear_logs();
    start_job(1, 1, 1);
    wait_done(1'b0, 20, seen);
    check("t4_done_seen", 64'(seen), 64'd1);
    exp_q = '{0};
    check_list("t4_a", a_log, exp_q);
    check_list("t4_b", b_log, exp_q);
    check_list("t4_wra", wa_log, exp_q);
    exp_q = '{1};
    check_list("t4_first", f_log, exp_q);
    check_list("t4_last", l_log, exp_q);
    exp_q = '{4};
    check_list("t4_wrt", wt_log, exp_q);
    exp_q = '{5};
    check_list("t4_done_t", dt_log, exp_q);
    tick();

    // M=2, N=3, K=2: non-square, separates the N and K strides
    clear_logs();
    start_job(2, 3, 2);
    wait_done(1'b0, 40, seen);
    check("t5_done_seen", 64'(seen), 64'd1);
    exp_q = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3};
    check_list("t5_a", a_log, exp_q);
    exp_q = '{0, 3, 1, 4, 2, 5, 0, 3, 1, 4, 2, 5};
    check_list("t5_b", b_log, exp_q);
    exp_q = '{0, 1, 2, 3, 4, 5};
    check_list("t5_wra", wa_log, exp_q);
    exp_q = '{5, 7, 9, 11, 13, 15};
    check_list("t5_wrt", wt_log, exp_q);
    exp_q = '{16};
    check_list("t5_done_t", dt_log, exp_q);
    tick();

    // K = 255: largest dimension value
    clear_logs();
    start_job(1, 1, 255);
    wait_done(1'b0, 400, seen);
    check("t6_done_seen", 64'(seen), 64'd1);
    check("t6_beats", 64'(a_log.size()), 64'd255);
    check("t6_last_a", 64'(a_log[a_log.size()-1]), 64'd254);
    check("t6_last_b", 64'(b_log[b_log.size()-1]), 64'd254);
    check("t6_last_flag", 64'(l_log[l_log.size()-1]), 64'd1);
    check("t6_first_flag", 64'(f_log[0]), 64'd1);
    exp_q = '{0};
    check_list("t6_wra", wa_log, exp_q);
    exp_q = '{259};
    check_list("t6_done_t", dt_log, exp_q);
    tick();

    // Abort during DRAIN: last write dropped, no done
    clear_logs();
    start_job(2, 2, 2);
    while (cyc - t0 < 9) tick();
    check("t7_busy_drain", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_busy_after", 64'(busy), 64'd0);
    repeat (6) tick();
    exp_q = '{0, 1, 2};
    check_list("t7_wra", wa_log, exp_q);
    check("t7_done_count", 64'(dt_log.size()), 64'd0);
    // fresh job afterwards
    clear_logs();
    start_job(1, 1, 1);
    wait_done(1'b0, 20, seen);
    exp_q = '{0};
    check_list("t7b_wra", wa_log, exp_q);
    exp_q = '{5};
    check_list("t7b_done_t", dt_log, exp_q);
    tick();

    // start while busy is ignored, cfg changes have no effect
    clear_logs();
    start_job(2, 2, 2);
    tick(); tick();
    cfg_m = 8'd3;
    cfg_n = 8'd3;
    cfg_k = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, 40, seen);
    check("t8_done_seen", 64'(seen), 64'd1);
    check_2x2x2_beats("t8");
    exp_q = '{12};
    check_list("t8_done_t", dt_log, exp_q);
    tick();

    // abort and start together in IDLE
    clear_logs();
    cfg_m = 8'd1;
    cfg_n = 8'd1;
    cfg_k = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t9_busy", 64'(busy), 64'd0);
    repeat (6) tick();
    check("t9_rdv_cycles", 64'(rv_cnt), 64'd0);
    check("t9_done_count", 64'(dt_log.size()), 64'd0);

    // reset asserted mid-RUN
    clear_logs();
    start_job(2, 2, 2);
    tick(); tick();
    check("t10_busy_run", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("t10_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t10_busy_idle", 64'(busy), 64'd0);
    check("t10_rdv_idle", 64'(rd_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencing controller for the matrix-multiply MAC datapath (C = A * B).
- Accepts a job of dimensions M x K times K x N.
- Walks the (i, j, k) index space, with k innermost, then j, then i.
- For each index it issues operand-fetch beats: A address, B address, and accumulate-first/last flags.
- Emits one C write address per output element, MAC_LAT cycles after that element's final beat is accepted.
- Sits between the job/config interface and the A/B operand memories plus the MAC unit.

Parameters:
- DIM_W, 8: width of each dimension field cfg_m/cfg_n/cfg_k.
- ADDR_W, 16: width of the A/B/C element addresses. Addresses wrap modulo 2^ADDR_W.
- MAC_LAT, 3: MAC pipeline latency in cycles, from beat accept to result valid. Legal range is 1 or more.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: job request, sampled in IDLE only.
- abort, input, 1: synchronous job cancel.
- cfg_m, input, DIM_W: rows of A and C.
- cfg_n, input, DIM_W: columns of B and C.
- cfg_k, input, DIM_W: inner dimension.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: one-cycle pulse together with done for an illegal job.
- rd_valid, output, 1: operand beat valid.
- rd_ready, input, 1: datapath accepts the beat.
- rd_addr_a, output, ADDR_W: i*K + k.
- rd_addr_b, output, ADDR_W: k*N + j.
- mac_first, output, 1: k == 0 (clear accumulator).
- mac_last, output, 1: k == K-1.
- wr_valid, output, 1: C result valid this cycle. There is no backpressure.
- wr_addr, output, ADDR_W: i*N + j.
- perf_cycles, output, 32: optional-feature counter.
- perf_stalls, output, 32: optional-feature counter.

Behaviour:
- Reset: state IDLE. All outputs are 0, all index, address and pipeline registers are 0, and perf counters are 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN: start=1 in cycle T latches cfg_m/n/k. RUN begins at T+1 with rd_valid=1 and i=j=k=0.
- start while not in IDLE is ignored.
- Zero dimension: start with any cfg field equal to 0 goes IDLE → DONE. done=1 and err=1 at T+1. No rd or wr beats are issued.
- RUN, beat transfer:
  - A beat is accepted when rd_valid && rd_ready.
  - While rd_ready=0, rd_addr_a, rd_addr_b, mac_first and mac_last are held stable, and rd_valid stays 1.
- RUN, index update on accept:
  - k increments first.
  - At k = K-1, k clears and j increments.
  - At j = N-1, j clears and i increments.
- Address generation uses incremental adders only; no multipliers.
  - rd_addr_a: row base plus k. The row base advances by K on each i increment.
  - rd_addr_b: k*N, advanced by adding N on each k step; plus j.
  - wr_addr: row base advancing by N; plus j.
- Write pipeline:
  - It is a MAC_LAT-deep shift register of {valid, wr_addr}.
  - It is loaded with valid=1 on every accepted beat that has mac_last=1.
  - The output stage drives wr_valid and wr_addr. A beat accepted in cycle t therefore produces wr_valid at t+MAC_LAT.
  - The pipeline shifts every cycle, independent of rd_ready.
- RUN → DRAIN: on acceptance of the final beat (i=M-1, j=N-1, k=K-1). rd_valid=0 from the next cycle.
- DRAIN → DONE: once the final wr_valid has been emitted.
- DONE: done=1 (and err=0 for a legal job) for exactly one cycle, then IDLE. busy falls in the same cycle done falls.
- Latency: with rd_ready held at 1, done asserts at T + M*N*K + MAC_LAT + 1.
- Abort:
  - abort=1 in any state forces IDLE next cycle.
  - It clears rd_valid and all write-pipeline valids; in-flight writes are dropped.
  - No done or err pulse is generated.
  - abort and start in the same IDLE cycle: abort wins, and the job is not started.
- Reset mid-job: immediate return to the reset state, asynchronously.
- Dimension value 2^DIM_W - 1 is legal. Index counters are DIM_W wide, and the terminal compare is against cfg-1.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- Defined:
  - perf_cycles counts every cycle where busy=1.
  - perf_stalls counts cycles with rd_valid=1 && rd_ready=0.
  - Both counters clear on job start.
  - Both counters hold their value after done until the next start.
  - Both counters saturate at 2^32 - 1.
- Undefined: counter logic is absent and both ports are driven constant 0.

Test Plan:
- 2x2x2 job, rd_ready=1, MAC_LAT=3:
  - rd_addr_a = 0,1,0,1,2,3,2,3; rd_addr_b = 0,2,1,3,0,2,1,3.
  - mac_first on beats 1,3,5,7; mac_last on beats 2,4,6,8.
  - wr_addr = 0,1,2,3 at start+5, +7, +9, +11.
  - done at start+12.
- Same job with rd_ready low on every other cycle:
  - Addresses are stable under stall and the wr order is unchanged.
  - With MATMUL_SEQ_PERF_EN: perf_stalls = 8 and perf_cycles = 20 (T+1 to T+20).
- cfg_k=0 → done=1 and err=1 at start+1, with zero rd_valid and wr_valid cycles. cfg 1x1x1 → one beat with mac_first=mac_last=1, wr_addr=0, done at start+5.
- Abort during DRAIN (after the final beat, before the last wr_valid) → no further wr_valid, no done, busy=0 next cycle. A fresh start afterwards runs normally.
- start while busy is ignored: cfg changes mid-job have no effect on the addresses.
- Abort and start together in IDLE → remains IDLE.
- rst_n asserted mid-RUN → all outputs 0 asynchronously; after release, IDLE.
